// File: rtl/ps2_keys_pkg.sv
// ps2_keys_pkg: shared constants for the PS/2 scan-code set 2 parser.
//   - protocol bytes (extended prefix, break prefix, BAT pass, control bytes)
//   - scan codes of the 16 keys used by the game controller
//   - bit index of each key in the held-key map
//   - parser FSM state enum
package ps2_keys_pkg;

    // Protocol bytes
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR_LO = 8'h00;
    localparam logic [7:0] SC_ERR_HI = 8'hFF;

    // Base-table key codes
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_C     = 8'h21;
    localparam logic [7:0] SC_N     = 8'h31;
    localparam logic [7:0] SC_Q     = 8'h15;

    // Extended-table key codes (received after E0)
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Bit positions in the held-key map
    localparam logic [3:0] KEY_SPACE = 4'd0;
    localparam logic [3:0] KEY_ENTER = 4'd1;
    localparam logic [3:0] KEY_ESC   = 4'd2;
    localparam logic [3:0] KEY_UP    = 4'd3;
    localparam logic [3:0] KEY_DOWN  = 4'd4;
    localparam logic [3:0] KEY_LEFT  = 4'd5;
    localparam logic [3:0] KEY_RIGHT = 4'd6;
    localparam logic [3:0] KEY_W     = 4'd7;
    localparam logic [3:0] KEY_A     = 4'd8;
    localparam logic [3:0] KEY_S     = 4'd9;
    localparam logic [3:0] KEY_D     = 4'd10;
    localparam logic [3:0] KEY_P     = 4'd11;
    localparam logic [3:0] KEY_R     = 4'd12;
    localparam logic [3:0] KEY_C     = 4'd13;
    localparam logic [3:0] KEY_N     = 4'd14;
    localparam logic [3:0] KEY_Q     = 4'd15;

    // Parser state: which prefixes of the current sequence have been seen
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parse_state_e;

    // Bytes that abort any pending prefix without touching the key map
    function automatic logic is_abort_byte(input logic [7:0] b);
        return (b == SC_PAUSE) || (b == SC_ACK) || (b == SC_RESEND) ||
               (b == SC_ERR_LO) || (b == SC_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// ps2_keymap: combinational scan-code to key-bit lookup.
//   code : scan code byte
//   ext  : 1 = look up in the extended (E0-prefixed) table, 0 = base table
//   hit  : code is one of the mapped keys in the selected table
//   idx  : bit index of the key in the held-key map (0 when no hit)
module ps2_keymap
    import ps2_keys_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output logic       hit,
    output logic [3:0] idx
);

    always_comb begin
        hit = 1'b1;
        idx = 4'd0;
        if (ext) begin
            case (code)
                SC_UP:    idx = KEY_UP;
                SC_DOWN:  idx = KEY_DOWN;
                SC_LEFT:  idx = KEY_LEFT;
                SC_RIGHT: idx = KEY_RIGHT;
                default:  hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_SPACE: idx = KEY_SPACE;
                SC_ENTER: idx = KEY_ENTER;
                SC_ESC:   idx = KEY_ESC;
                SC_W:     idx = KEY_W;
                SC_A:     idx = KEY_A;
                SC_S:     idx = KEY_S;
                SC_D:     idx = KEY_D;
                SC_P:     idx = KEY_P;
                SC_R:     idx = KEY_R;
                SC_C:     idx = KEY_C;
                SC_N:     idx = KEY_N;
                SC_Q:     idx = KEY_Q;
                default:  hit = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_parser.sv
// ps2_parser: turns the PS/2 scan-code set 2 byte stream into a level map
// of currently held keys.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous reset, active low
//   ps2_byte  : last received byte, valid while ps2_state is high
//   ps2_state : byte-valid level; each rising transition carries one byte
//   keys      : registered held-key map, bit = 1 while the key is down
module ps2_parser
    import ps2_keys_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ps2_byte,
    input  logic        ps2_state,
    output logic [15:0] keys
);

    logic         state_d;
    logic         accept;
    parse_state_e state, state_nxt;
    logic [15:0]  keys_nxt;
    logic         in_ext;
    logic         in_brk;
    logic         map_hit;
    logic [3:0]   map_idx;

    // Rising-edge detect on the byte-valid level: one byte per transition,
    // however long the receiver keeps the level high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_d <= 1'b0;
        else        state_d <= ps2_state;
    end

    assign accept = ps2_state & ~state_d;

    assign in_ext = (state == ST_EXT) || (state == ST_EXT_BRK);
    assign in_brk = (state == ST_BRK) || (state == ST_EXT_BRK);

    // Table choice follows the prefix: after E0 only extended codes map.
    ps2_keymap u_keymap (
        .code (ps2_byte),
        .ext  (in_ext),
        .hit  (map_hit),
        .idx  (map_idx)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: prefixes accumulate, any other byte ends the sequence
    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (ps2_byte == SC_EXT)
                state_nxt = ST_EXT;
            else if (ps2_byte == SC_BRK)
                state_nxt = in_ext ? ST_EXT_BRK : ST_BRK;
            else
                state_nxt = ST_IDLE;
        end
    end

    // FSM output: key map update on a terminating byte
    always_comb begin
        keys_nxt = keys;
        if (accept) begin
            if (ps2_byte == SC_BAT) begin
                // Keyboard hot-plugged: nothing can still be held
                keys_nxt = '0;
            end else if (ps2_byte != SC_EXT && ps2_byte != SC_BRK &&
                         !is_abort_byte(ps2_byte) && map_hit) begin
                // Set on make, clear on break; repeats are idempotent
                keys_nxt[map_idx] = ~in_brk;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) keys <= '0;
        else        keys <= keys_nxt;
    end

endmodule

// File: tb/tb_ps2_parser.sv
module tb_ps2_parser;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ps2_byte;
    logic        ps2_state;
    logic [15:0] keys;

    int checks = 0;
    int errors = 0;

    ps2_parser dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_byte  (ps2_byte),
        .ps2_state (ps2_state),
        .keys      (keys)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Key table as data: code and whether it needs the E0 prefix, per bit.
    logic [7:0] key_code [16];
    bit         key_ext  [16];
    logic [15:0] mkeys;
    logic [7:0]  prefix[$];   // pending E0/F0 bytes of the current sequence

    initial begin
        key_code = '{8'h29, 8'h5A, 8'h76, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D,
                     8'h1C, 8'h1B, 8'h23, 8'h4D, 8'h2D, 8'h21, 8'h31, 8'h15};
        key_ext  = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    end

    task automatic model_reset();
        mkeys = '0;
        prefix.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit ext, brk;
        int last_e0;
        if (b == 8'hE0 || b == 8'hF0) begin
            prefix.push_back(b);
        end else if (b == 8'hAA) begin
            mkeys = '0;
            prefix.delete();
        end else if (b inside {8'hE1, 8'hFA, 8'hFE, 8'h00, 8'hFF}) begin
            prefix.delete();
        end else begin
            // Extended if any E0 is pending; break only if F0 follows the last E0
            ext = 0; brk = 0; last_e0 = -1;
            foreach (prefix[i]) if (prefix[i] == 8'hE0) begin ext = 1; last_e0 = i; end
            foreach (prefix[i]) if (prefix[i] == 8'hF0 && i > last_e0) brk = 1;
            for (int k = 0; k < 16; k++)
                if (key_code[k] == b && key_ext[k] == ext) mkeys[k] = !brk;
            prefix.delete();
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: keys=%h expected=%h", name, act, exp);
        end
    endtask

    // One byte on a rising ps2_state; level held for 'hold' edges with the
    // byte bus scrambled after the first, then dropped for 'gap' edges.
    task automatic send(input logic [7:0] b, input int hold, input int gap);
        @(negedge clk);
        ps2_byte  = b;
        ps2_state = 1'b1;
        @(posedge clk); #1;
        model_byte(b);
        chk($sformatf("byte %h", b), keys, mkeys);
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            ps2_byte = 8'($urandom);
            @(posedge clk); #1;
            chk("held", keys, mkeys);
        end
        @(negedge clk);
        ps2_state = 1'b0;
        ps2_byte  = 8'($urandom);
        for (int g = 1; g < gap; g++) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] pick;
    int r;

    initial begin
        rst_n = 1'b0; ps2_byte = 8'h00; ps2_state = 1'b0;
        model_reset();
        vecs = '{
            '{8'h29, 16'h0001}, '{8'hF0, 16'h0001}, '{8'h29, 16'h0000},
            '{8'hE0, 16'h0000}, '{8'h75, 16'h0008}, '{8'hE0, 16'h0008},
            '{8'hF0, 16'h0008}, '{8'h75, 16'h0000}, '{8'hE0, 16'h0000},
            '{8'h29, 16'h0000}, '{8'h1D, 16'h0080}, '{8'h1C, 16'h0180},
            '{8'hE0, 16'h0180}, '{8'h74, 16'h01C0}, '{8'hF0, 16'h01C0},
            '{8'h1C, 16'h00C0}, '{8'h3C, 16'h00C0}, '{8'hF0, 16'h00C0},
            '{8'h3C, 16'h00C0}, '{8'h29, 16'h00C1}, '{8'h29, 16'h00C1},
            '{8'hF0, 16'h00C1}, '{8'h4D, 16'h00C1}, '{8'h15, 16'h80C1},
            '{8'hE0, 16'h80C1}, '{8'hFA, 16'h80C1}, '{8'h75, 16'h80C1},
            '{8'hF0, 16'h80C1}, '{8'hE0, 16'h80C1}, '{8'h72, 16'h80D1},
            '{8'hAA, 16'h0000}
        };
        repeat (3) @(posedge clk);
        #1 chk("reset", keys, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // First byte held high for several edges: one change, then steady
        send(8'h29, 5, 1);
        chk("hold steady", keys, 16'h0001);
        send(8'hF0, 1, 1);
        send(8'h29, 1, 1);

        // Directed table
        foreach (vecs[i]) begin
            send(vecs[i].b, 1 + (i % 3), 1 + (i % 2));
            chk($sformatf("vec %0d", i), keys, vecs[i].exp);
        end

        // Asynchronous reset in the middle of E0 F0
        send(8'hE0, 1, 1);
        send(8'h75, 1, 1);
        chk("up set", keys, 16'h0008);
        send(8'hE0, 1, 1);
        send(8'hF0, 1, 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1 chk("async reset", keys, 16'h0000);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        send(8'h75, 1, 1);
        chk("prefix dropped", keys, 16'h0000);
        send(8'h29, 1, 1);
        chk("space after reset", keys, 16'h0001);

        // ps2_state already high when reset releases
        @(negedge clk);
        rst_n = 1'b0; ps2_byte = 8'h5A; ps2_state = 1'b1;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("accept at release", keys, 16'h0002);
        model_byte(8'h5A);
        @(negedge clk) ps2_state = 1'b0;

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 12)      pick = 8'hE0;
            else if (r < 24) pick = 8'hF0;
            else if (r < 26) pick = 8'hAA;
            else if (r < 30) begin
                case ($urandom_range(0, 4))
                    0: pick = 8'hE1; 1: pick = 8'hFA; 2: pick = 8'hFE;
                    3: pick = 8'h00; default: pick = 8'hFF;
                endcase
            end
            else if (r < 88) pick = key_code[$urandom_range(0, 15)];
            else             pick = 8'($urandom);
            send(pick, $urandom_range(1, 3), $urandom_range(1, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
